// File: rtl/angle_comb_pkg.sv
// rtl/angle_comb_pkg.sv - shared types and helpers for the angle-combination value reader
package angle_comb_pkg;

   localparam int DEF_EXP_LEN      = 8;
   localparam int DEF_MANTISSA_LEN = 23;

   typedef struct packed {
      logic                        sign;
      logic [DEF_EXP_LEN-1:0]      exp;
      logic [DEF_MANTISSA_LEN-1:0] mant;
   } fp_word_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } reader_state_e;

   function automatic int word_width(input int exp_len, input int mantissa_len);
      return 1 + exp_len + mantissa_len;
   endfunction

endpackage

// File: rtl/angle_comb_skid_fifo.sv
// rtl/angle_comb_skid_fifo.sv - two-entry FIFO holding {word, index, last} between memory and stream
module angle_comb_skid_fifo #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] entry [2];
   logic              wr_ptr;
   logic              rd_ptr;

   // On a full FIFO wr_ptr == rd_ptr; the popped head is consumed before the write lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         entry[0] <= '0;
         entry[1] <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
      end else begin
         if (push) begin
            entry[wr_ptr] <= push_data;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

   assign head_data = entry[rd_ptr];

endmodule

// File: rtl/angle_combination_reader.sv
// rtl/angle_combination_reader.sv - reads every angle-combination word in address order and streams it out
// Define ANGLE_COMB_READER_FTZ_EN to flush subnormal words to signed zero as they enter the FIFO.
module angle_combination_reader
   import angle_comb_pkg::*;
#(
   parameter  int EXP_LEN        = 8,
   parameter  int MANTISSA_LEN   = 23,
   parameter  int NUM_ANGLE_COMB = 8,
   localparam int WORD_W         = word_width(EXP_LEN, MANTISSA_LEN),
   localparam int ADDR_W         = (NUM_ANGLE_COMB > 1) ? $clog2(NUM_ANGLE_COMB) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_value_addr,
   input  logic [WORD_W-1:0] mem_value_datao,
   output logic [WORD_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ANGLE_COMB - 1);
   localparam int                ENTRY_W   = WORD_W + ADDR_W + 1;

   reader_state_e     state;
   reader_state_e     state_next;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] inflight_idx;
   logic              inflight;
   logic              issue;
   logic              pop;
   logic [1:0]        fifo_count;
   logic [1:0]        occupancy;
   logic [WORD_W-1:0] push_word;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;
   logic [WORD_W-1:0] head_word;
   logic [ADDR_W-1:0] head_idx;
   logic              head_last;

   assign out_valid = (fifo_count != 2'd0);
   assign pop       = out_valid && out_ready;
   // Slots already claimed once this cycle's pop is retired; keeps one word per cycle streaming.
   assign occupancy = fifo_count - 2'(pop) + 2'(inflight);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = ISSUE;
         ISSUE:   if (issue && addr == LAST_ADDR) state_next = DRAIN;
         DRAIN:   if (pop && head_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      issue = (state == ISSUE) && (occupancy < 2'd2);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr         <= '0;
         inflight     <= 1'b0;
         inflight_idx <= '0;
         done         <= 1'b0;
      end else begin
         inflight <= issue;
         done     <= pop && head_last;
         if (issue) begin
            inflight_idx <= addr;
         end
         if (state == IDLE && start) begin
            addr <= '0;
         end else if (issue && addr != LAST_ADDR) begin
            addr <= addr + 1'b1;
         end
      end
   end

   assign mem_value_addr = addr;

   always_comb begin
      push_word = mem_value_datao;
`ifdef ANGLE_COMB_READER_FTZ_EN
      if (mem_value_datao[WORD_W-2 -: EXP_LEN] == '0 && mem_value_datao[MANTISSA_LEN-1:0] != '0) begin
         push_word = {mem_value_datao[WORD_W-1], {(WORD_W-1){1'b0}}};
      end
`endif
   end

   assign push_entry = {push_word, inflight_idx, (inflight_idx == LAST_ADDR)};

   angle_comb_skid_fifo #(
      .DATA_W (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .count     (fifo_count)
   );

   assign {head_word, head_idx, head_last} = head_entry;
   assign out_data  = out_valid ? head_word : '0;
   assign out_index = out_valid ? head_idx  : '0;
   assign out_last  = out_valid && head_last;

endmodule

// File: tb/tb_angle_combination_reader.sv
// tb/tb_angle_combination_reader.sv - scoreboard bench for angle_combination_reader
module tb_angle_combination_reader;
   import angle_comb_pkg::*;

   localparam int NUM    = 8;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] mem_value_addr;
   logic [WORD_W-1:0] mem_value_datao;
   logic [WORD_W-1:0] out_data;
   logic [ADDR_W-1:0] out_index;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;

   always #5 clk = ~clk;

   angle_combination_reader #(
      .EXP_LEN        (8),
      .MANTISSA_LEN   (23),
      .NUM_ANGLE_COMB (NUM)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .mem_value_addr  (mem_value_addr),
      .mem_value_datao (mem_value_datao),
      .out_data        (out_data),
      .out_index       (out_index),
      .out_last        (out_last),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .busy            (busy),
      .done            (done)
   );

   logic [WORD_W-1:0] mem [NUM];
   always @(posedge clk) mem_value_datao <= mem[mem_value_addr];

   int errors = 0;
   int checks = 0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
      end
   endtask

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [ADDR_W-1:0] idx;
      logic              last;
   } exp_t;

   exp_t sb[$];
   exp_t sb_head;

   int cyc = 0;
   int accepts = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int first_acc_cyc = 0;
   int last_acc_cyc = 0;
   int valid_rise_cyc = 0;
   logic              stalled = 1'b0;
   logic              prev_valid = 1'b0;
   logic [WORD_W-1:0] held_data;
   logic [ADDR_W-1:0] held_idx;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (reset) begin
         stalled    = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (out_valid && !prev_valid) valid_rise_cyc = cyc;
         if (stalled) begin
            check_value("stall_valid", 64'(out_valid), 64'd1);
            check_value("stall_data", 64'(out_data), 64'(held_data));
            check_value("stall_index", 64'(out_index), 64'(held_idx));
         end
         if (out_valid && out_ready) begin
            check_value("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               sb_head = sb.pop_front();
               check_value("word_data", 64'(out_data), 64'(sb_head.data));
               check_value("word_index", 64'(out_index), 64'(sb_head.idx));
               check_value("word_last", 64'(out_last), 64'(sb_head.last));
            end
            if (out_index == '0) first_acc_cyc = cyc;
            if (out_last) last_acc_cyc = cyc;
            accepts++;
         end
         stalled    = out_valid && !out_ready;
         held_data  = out_data;
         held_idx   = out_index;
         prev_valid = out_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WORD_W-1:0] expect_word(input logic [WORD_W-1:0] w);
      fp_word_t f;
      f = w;
`ifdef ANGLE_COMB_READER_FTZ_EN
      if (f.exp == '0 && f.mant != '0) f.mant = '0;
`endif
      return f;
   endfunction

   function automatic logic ready_for(input int mode, input int n);
      case (mode)
         1:       return (n % 2) == 0;
         2:       return n >= 20;
         default: return 1'b1;
      endcase
   endfunction

   task automatic check_idle_outputs(input string tag);
      check_value({tag, "_valid"}, 64'(out_valid), 64'd0);
      check_value({tag, "_data"}, 64'(out_data), 64'd0);
      check_value({tag, "_index"}, 64'(out_index), 64'd0);
      check_value({tag, "_last"}, 64'(out_last), 64'd0);
      check_value({tag, "_busy"}, 64'(busy), 64'd0);
      check_value({tag, "_done"}, 64'(done), 64'd0);
      check_value({tag, "_addr"}, 64'(mem_value_addr), 64'd0);
   endtask

   task automatic run_pass(input int mode, input int extra_at, input int abort_at, input bit timing);
      int n;
      int acc0;
      int done0;
      int start_cyc;
      bit aborted;
      aborted = 1'b0;
      acc0    = accepts;
      done0   = done_cnt;
      for (int i = 0; i < NUM; i++) begin
         sb.push_back({expect_word(mem[i]), ADDR_W'(i), (i == NUM - 1)});
      end
      out_ready = ready_for(mode, 0);
      start     = 1'b1;
      tick();
      start     = 1'b0;
      start_cyc = cyc;
      n         = 1;
      while (done_cnt == done0 && n < 300 && !aborted) begin
         if (mode == 2 && n == 20) begin
            check_value("stall_addr", 64'(mem_value_addr), 64'd2);
            check_value("stall_head_valid", 64'(out_valid), 64'd1);
            check_value("stall_head_index", 64'(out_index), 64'd0);
         end
         out_ready = ready_for(mode, n);
         start     = (n == extra_at);
         if (abort_at > 0 && accepts - acc0 == abort_at) begin
            out_ready = 1'b0;
            start     = 1'b0;
            reset     = 1'b1;
            tick();
            reset = 1'b0;
            check_idle_outputs("abort");
            repeat (5) tick();
            check_value("abort_no_done", 64'(done_cnt - done0), 64'd0);
            sb.delete();
            aborted = 1'b1;
         end else begin
            tick();
            n++;
         end
      end
      start     = 1'b0;
      out_ready = 1'b1;
      if (!aborted) begin
         repeat (4) tick();
         check_value("done_count", 64'(done_cnt - done0), 64'd1);
         check_value("word_count", 64'(accepts - acc0), 64'(NUM));
         check_value("sb_empty", 64'(sb.size()), 64'd0);
         check_value("done_timing", 64'(done_cyc - last_acc_cyc), 64'd1);
         check_value("idle_after", 64'(busy), 64'd0);
         if (timing) begin
            check_value("latency", 64'(valid_rise_cyc - start_cyc), 64'd2);
            check_value("back_to_back", 64'(last_acc_cyc - first_acc_cyc), 64'(NUM - 1));
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < NUM; i++) mem[i] = 32'h3F80_0000 + 32'(i);
      repeat (3) tick();
      reset = 1'b0;
      check_idle_outputs("reset");

      run_pass(0, 0, 0, 1'b1);
      run_pass(1, 0, 0, 1'b0);
      run_pass(2, 0, 0, 1'b0);
      run_pass(0, 4, 0, 1'b0);
      run_pass(1, 0, 4, 1'b0);
      run_pass(0, 0, 0, 1'b1);

      mem[0] = 32'h8000_0001;
      mem[3] = 32'h0000_0400;
      mem[5] = 32'h0080_0001;
      run_pass(0, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
